// File: rtl/huc6280_timer_irq.sv
// HuC6280 on-chip 7-bit interval timer and interrupt controller.
// Decodes its slice of the hardware I/O page and drives the three masked IRQ lines.
module huc6280_timer_irq #(
  parameter int unsigned PRESCALE = 1024,
  parameter logic [7:0]  IO_PAGE  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] addr,
  input  logic [7:0]  dIn,
  output logic [7:0]  dOut,
  input  logic        re,
  input  logic        we,
  output logic        hit,
  input  logic        irq1_n,
  input  logic        irq2_n,
  output logic        tiq,
  output logic        irq1,
  output logic        irq2
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PTERM = PW'(PRESCALE - 1);

  logic [6:0]    reload_q, reload_d;
  logic [6:0]    counter_q, counter_d;
  logic          enable_q, enable_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    mask_q, mask_d;
  logic          tiq_pend_q, tiq_pend_d;
  logic [7:0]    dout_q, dout_d;

  logic       page_hit, tmr_sel, irq_sel;
  logic [1:0] sel;
  logic       wr_tmr, wr_irq, tick, underflow;
  logic [7:0] rdata;

  // Address bits between the region field and the register select are mirrored.
  logic unused;
  assign unused = ^{addr[9:2], dIn[7]};

  assign page_hit = (addr[20:13] == IO_PAGE);
  assign tmr_sel  = page_hit && (addr[12:10] == 3'b011);
  assign irq_sel  = page_hit && (addr[12:10] == 3'b101);
  assign hit      = tmr_sel || irq_sel;
  assign sel      = addr[1:0];
  assign wr_tmr   = we && tmr_sel;
  assign wr_irq   = we && irq_sel;

  always_comb begin
    reload_d   = reload_q;
    counter_d  = counter_q;
    enable_d   = enable_q;
    presc_d    = presc_q;
    mask_d     = mask_q;
    tiq_pend_d = tiq_pend_q;
    tick       = 1'b0;

    if (enable_q) begin
      if (presc_q == PTERM) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    underflow = tick && (counter_q == 7'd0);
    if (tick) counter_d = (counter_q == 7'd0) ? reload_q : counter_q - 7'd1;

    if (wr_tmr && sel == 2'd0) reload_d = dIn[6:0];
    if (wr_tmr && sel == 2'd1) begin
      enable_d = dIn[0];
      // Only a rising enable restarts the count; 1->1 leaves it running.
      if (dIn[0] && !enable_q) begin
        counter_d = reload_q;
        presc_d   = '0;
      end
    end
    if (wr_irq && sel == 2'd2) mask_d = dIn[2:0];
    if (wr_irq && sel == 2'd3) tiq_pend_d = 1'b0;
    if (underflow) tiq_pend_d = 1'b1;
  end

  always_comb begin
    rdata = 8'h00;
    if (tmr_sel) begin
      case (sel)
        2'd0:    rdata = {1'b0, counter_q};
        2'd1:    rdata = {7'b0, enable_q};
        default: rdata = 8'h00;
      endcase
    end else if (irq_sel) begin
      case (sel)
        2'd2:    rdata = {5'b0, mask_q};
        2'd3:    rdata = {5'b0, tiq_pend_q, ~irq1_n, ~irq2_n};
        default: rdata = 8'h00;
      endcase
    end
    dout_d = (re && hit) ? rdata : dout_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q   <= 7'd0;
      counter_q  <= 7'd0;
      enable_q   <= 1'b0;
      presc_q    <= '0;
      mask_q     <= 3'b000;
      tiq_pend_q <= 1'b0;
      dout_q     <= 8'h00;
    end else begin
      reload_q   <= reload_d;
      counter_q  <= counter_d;
      enable_q   <= enable_d;
      presc_q    <= presc_d;
      mask_q     <= mask_d;
      tiq_pend_q <= tiq_pend_d;
      dout_q     <= dout_d;
    end
  end

  assign dOut = dout_q;
  assign tiq  = tiq_pend_q & ~mask_q[2];
  assign irq1 = ~irq1_n & ~mask_q[1];
  assign irq2 = ~irq2_n & ~mask_q[0];

endmodule
